execute_md: RTL and testbench

- Parametrised next-generation execute stage for the RV32 pipeline.
- Handles ALU ops and branch/jump resolution in a single cycle, as the current execute stage does.
- Adds forwarding from FWD_PORTS older pipeline stages and an iterative RV32M multiply/divide unit.
- The multiply/divide unit stalls upstream through a valid/ready handshake and can be aborted by flush.

---
 rtl/execute_md.sv | 259 +++++++++++++++++++++++++
 tb/tb_execute_md.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// Single-cycle ALU/branch execute stage with operand forwarding and an
// iterative RV32M multiply/divide unit that holds off upstream while it runs.
//
// state  | meaning
// IDLE   | accepting; ALU/branch ops complete combinationally
// RUN    | MD unit iterating, BITS_PER_CYCLE bits per cycle
// DONE   | MD result presented for one cycle
module execute_md #(
    parameter int XLEN           = 32,
    parameter int FWD_PORTS      = 2,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           reg_a,
    input  logic [XLEN-1:0]           reg_b,
    input  logic [XLEN-1:0]           imm,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    input  logic [5*FWD_PORTS-1:0]    fwd_rd,
    input  logic [FWD_PORTS-1:0]      fwd_we,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_data,
    input  logic [3:0]                alu_op,
    input  logic                      is_md,
    input  logic [2:0]                funct3,
    input  logic                      is_jump,
    input  logic                      jump_conditional,
    input  logic                      a_sel,
    input  logic                      b_sel,
    output logic                      out_valid,
    output logic [XLEN-1:0]           result,
    output logic                      jump,
    output logic                      busy
);

    localparam int N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int SHW    = $clog2(XLEN);
    localparam int MW     = XLEN + BITS_PER_CYCLE;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N_ITER - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
    logic [SHW-1:0]  shamt;
    logic            br_taken, accept;

    logic [XLEN-1:0] md_hi, md_lo, md_opd;
    logic [2:0]      md_f3;
    logic            md_neg_q, md_neg_r;
    logic [CW-1:0]   md_cnt;

    logic            sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, md_special;

    logic [MW-1:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nxt, mul_lo_nxt;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_rem, div_quo;
    logic [2*XLEN-1:0] md_prod, md_prod_s;
    logic [XLEN-1:0]   md_res;

    // Lowest-numbered (youngest) matching source wins, so scan from the oldest down.
    always_comb begin
        fwd_a = reg_a;
        fwd_b = reg_b;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_we[i] && (rs1 != 5'd0) && (fwd_rd[5*i +: 5] == rs1))
                fwd_a = fwd_data[XLEN*i +: XLEN];
            if (fwd_we[i] && (rs2 != 5'd0) && (fwd_rd[5*i +: 5] == rs2))
                fwd_b = fwd_data[XLEN*i +: XLEN];
        end
    end

    assign op_a  = a_sel ? pc : fwd_a;
    assign op_b  = b_sel ? imm : fwd_b;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'd0:    br_taken = (fwd_a == fwd_b);
            3'd1:    br_taken = (fwd_a != fwd_b);
            3'd4:    br_taken = $signed(fwd_a) < $signed(fwd_b);
            3'd5:    br_taken = $signed(fwd_a) >= $signed(fwd_b);
            3'd6:    br_taken = fwd_a < fwd_b;
            3'd7:    br_taken = fwd_a >= fwd_b;
            default: br_taken = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready & ~flush & reset;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (funct3)
            3'd1, 3'd4, 3'd6: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'd2:             sgn_a = 1'b1;
            default:          ;
        endcase
    end

    assign neg_a      = sgn_a & fwd_a[XLEN-1];
    assign neg_b      = sgn_b & fwd_b[XLEN-1];
    assign mag_a      = neg_a ? -fwd_a : fwd_a;
    assign mag_b      = neg_b ? -fwd_b : fwd_b;
    assign div_zero   = (fwd_b == '0);
    assign div_ovf    = ~funct3[0] & (fwd_a == MOST_NEG) & (fwd_b == ALL_ONES);
    assign md_special = funct3[2] & (div_zero | div_ovf);

    // Shift-add multiply: hi:lo holds partial product, lo shifts out consumed multiplier bits.
    assign mul_sum    = {{BITS_PER_CYCLE{1'b0}}, md_hi}
                      + MW'(md_opd) * MW'(md_lo[BITS_PER_CYCLE-1:0]);
    assign mul_hi_nxt = mul_sum[MW-1:BITS_PER_CYCLE];
    assign mul_lo_nxt = {mul_sum[BITS_PER_CYCLE-1:0], md_lo[XLEN-1:BITS_PER_CYCLE]};

    always_comb begin
        div_rem   = md_hi;
        div_quo   = md_lo;
        div_trial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            div_trial = {div_rem, div_quo[XLEN-1]};
            div_quo   = {div_quo[XLEN-2:0], 1'b0};
            if (div_trial >= {1'b0, md_opd}) begin
                div_trial  = div_trial - {1'b0, md_opd};
                div_quo[0] = 1'b1;
            end
            div_rem = div_trial[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && is_md) state_nxt = md_special ? S_DONE : S_RUN;
            S_RUN: begin
                if (flush)               state_nxt = S_IDLE;
                else if (md_cnt == '0)   state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Special divides preload quotient (lo) and remainder (hi) with signs cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_hi    <= '0;
            md_lo    <= '0;
            md_opd   <= '0;
            md_f3    <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_md) begin
                        md_f3  <= funct3;
                        md_cnt <= CNT_LAST;
                        if (md_special) begin
                            md_neg_q <= 1'b0;
                            md_neg_r <= 1'b0;
                            md_opd   <= '0;
                            md_lo    <= div_zero ? ALL_ONES : MOST_NEG;
                            md_hi    <= div_zero ? fwd_a : '0;
                        end else begin
                            md_neg_q <= neg_a ^ neg_b;
                            md_neg_r <= neg_a;
                            md_hi    <= '0;
                            md_lo    <= funct3[2] ? mag_a : mag_b;
                            md_opd   <= funct3[2] ? mag_b : mag_a;
                        end
                    end
                end
                S_RUN: begin
                    if (md_f3[2]) begin
                        md_hi <= div_rem;
                        md_lo <= div_quo;
                    end else begin
                        md_hi <= mul_hi_nxt;
                        md_lo <= mul_lo_nxt;
                    end
                    if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign md_prod   = {md_hi, md_lo};
    assign md_prod_s = md_neg_q ? -md_prod : md_prod;

    always_comb begin
        md_res = '0;
        if (!md_f3[2])
            md_res = (md_f3 == 3'd0) ? md_prod_s[XLEN-1:0] : md_prod_s[2*XLEN-1:XLEN];
        else if (md_f3[1])
            md_res = md_neg_r ? -md_hi : md_hi;
        else
            md_res = md_neg_q ? -md_lo : md_lo;
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        result    = '0;
        jump      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready  = 1'b1;
                busy      = 1'b0;
                out_valid = accept & ~is_md;
                result    = out_valid ? alu_res : '0;
                jump      = out_valid & is_jump & (~jump_conditional | br_taken);
            end
            S_DONE: begin
                out_valid = ~flush;
                result    = flush ? '0 : md_res;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: two instances (1 and 4 bits per MD cycle)
// share stimulus and are checked each cycle against a behavioural model.
module tb_execute_md;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush;
    logic [31:0] pc, reg_a, reg_b, imm;
    logic [4:0]  rs1, rs2;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic [63:0] fwd_data;
    logic [3:0]  alu_op;
    logic        is_md;
    logic [2:0]  funct3;
    logic        is_jump, jump_conditional, a_sel, b_sel;

    logic        ov [2];
    logic        jmp [2];
    logic        rdy [2];
    logic        bsy [2];
    logic [31:0] res [2];

    int checks = 0;
    int errors = 0;

    execute_md #(.XLEN(32), .FWD_PORTS(2), .BITS_PER_CYCLE(1)) u_md1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .flush(flush),
        .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .rs1(rs1), .rs2(rs2),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_data(fwd_data), .alu_op(alu_op),
        .is_md(is_md), .funct3(funct3), .is_jump(is_jump), .jump_conditional(jump_conditional),
        .a_sel(a_sel), .b_sel(b_sel), .out_valid(ov[0]), .result(res[0]), .jump(jmp[0]),
        .busy(bsy[0]));

    execute_md #(.XLEN(32), .FWD_PORTS(2), .BITS_PER_CYCLE(4)) u_md4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .flush(flush),
        .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .rs1(rs1), .rs2(rs2),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_data(fwd_data), .alu_op(alu_op),
        .is_md(is_md), .funct3(funct3), .is_jump(is_jump), .jump_conditional(jump_conditional),
        .a_sel(a_sel), .b_sel(b_sel), .out_valid(ov[1]), .result(res[1]), .jump(jmp[1]),
        .busy(bsy[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rv);
        logic found = 1'b0;
        pick = rv;
        for (int i = 0; i < 2; i++)
            if (!found && rs != 0 && fwd_we[i] && fwd_rd[5*i +: 5] == rs) begin
                pick  = fwd_data[32*i +: 32];
                found = 1'b1;
            end
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << b[4:0];
            3: return (sa < sb) ? 32'd1 : 32'd0;
            4: return (a < b) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a >> b[4:0];
            7: return 32'(sa >>> b[4:0]);
            8: return a | b;
            9: return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            0: return a == b;
            1: return a != b;
            4: return int'(a) < int'(b);
            5: return int'(a) >= int'(b);
            6: return a < b;
            7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pu = {32'd0, a} * {32'd0, b};
        longint      ps = longint'(int'(a)) * longint'(int'(b));
        longint      psu = longint'(int'(a)) * longint'({32'd0, b});
        logic [63:0] v;
        case (f)
            0: return pu[31:0];
            1: begin v = ps;  return v[63:32]; end
            2: begin v = psu; return v[63:32]; end
            3: return pu[63:32];
            4: if (b == 0) return 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
               else return 32'(int'(a) / int'(b));
            5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            6: if (b == 0) return a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
               else return 32'(int'(a) % int'(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // left: 0 = idle, 1 = result cycle, >1 = still working
    int          left [2] = '{0, 0};
    int          nxt  [2] = '{0, 0};
    logic [31:0] pend [2];
    int          niter [2] = '{32, 8};

    always @(negedge clk) begin
        logic [31:0] fa, fb, er;
        logic        acc, ev, ej, er_rdy, eb, sp;
        if (!reset) begin left[0] = 0; left[1] = 0; end
        fa  = pick(rs1, reg_a);
        fb  = pick(rs2, reg_b);
        acc = in_valid && !flush && reset;
        sp  = funct3[2] && (fb == 0 || (!funct3[0] && fa == 32'h80000000 && fb == 32'hFFFFFFFF));
        for (int d = 0; d < 2; d++) begin
            if (left[d] == 0) begin
                er_rdy = 1'b1; eb = 1'b0;
                ev = acc && !is_md;
                er = ev ? alu_model(alu_op, a_sel ? pc : fa, b_sel ? imm : fb) : 32'd0;
                ej = ev && is_jump && (!jump_conditional || br_model(funct3, fa, fb));
                nxt[d] = (acc && is_md) ? (sp ? 1 : niter[d] + 1) : 0;
                if (acc && is_md) pend[d] = md_model(funct3, fa, fb);
            end else if (left[d] == 1) begin
                er_rdy = 1'b0; eb = 1'b1; ev = !flush; ej = 1'b0;
                er = ev ? pend[d] : 32'd0;
                nxt[d] = 0;
            end else begin
                er_rdy = 1'b0; eb = 1'b1; ev = 1'b0; ej = 1'b0; er = 32'd0;
                nxt[d] = flush ? 0 : left[d] - 1;
            end
            chk($sformatf("model out_valid dut%0d", d), 32'(ov[d]), 32'(ev));
            chk($sformatf("model result dut%0d", d), res[d], er);
            chk($sformatf("model jump dut%0d", d), 32'(jmp[d]), 32'(ej));
            chk($sformatf("model in_ready dut%0d", d), 32'(rdy[d]), 32'(er_rdy));
            chk($sformatf("model busy dut%0d", d), 32'(bsy[d]), 32'(eb));
        end
    end

    always @(posedge clk) begin
        left[0] = nxt[0];
        left[1] = nxt[1];
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_in();
        in_valid = 0; flush = 0; pc = 32'h100; reg_a = 0; reg_b = 0; imm = 0;
        rs1 = 1; rs2 = 2; fwd_rd = 0; fwd_we = 0; fwd_data = 0; alu_op = 0;
        is_md = 0; funct3 = 0; is_jump = 0; jump_conditional = 0; a_sel = 0; b_sel = 0;
    endtask

    // Present one instruction, then watch both DUTs for their first out_valid.
    task automatic fire(input string nm, input logic [31:0] eres, input logic ejmp,
                        input int l0, input int l1);
        int          lat [2] = '{-1, -1};
        logic [31:0] got [2];
        logic        gj  [2];
        @(posedge clk); #1 in_valid = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (lat[d] < 0 && ov[d]) begin lat[d] = k; got[d] = res[d]; gj[d] = jmp[d]; end
            @(posedge clk); #1 in_valid = 0;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s latency dut%0d", nm, d), lat[d], (d == 0) ? l0 : l1);
            if (lat[d] >= 0) begin
                chk($sformatf("%s result dut%0d", nm, d), got[d], eres);
                chk($sformatf("%s jump dut%0d", nm, d), 32'(gj[d]), 32'(ejmp));
            end
        end
    endtask

    task automatic md_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eres, input int l0, input int l1);
        clear_in();
        is_md = 1; funct3 = f; reg_a = a; reg_b = b;
        fire(nm, eres, 1'b0, l0, l1);
        is_md = 0;
    endtask

    initial begin
        clear_in();
        reset = 0;
        in_valid = 1;
        @(negedge clk);
        chk("reset out_valid", 32'(ov[0]), 0);
        chk("reset result", res[1], 0);
        chk("reset in_ready", 32'(rdy[0]), 1);
        @(posedge clk); #3 reset = 1;
        clear_in();

        // ADD with both ports forwarding rs1: youngest port 0 wins
        rs1 = 5; rs2 = 7; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11;
        fwd_data = {32'h10, 32'h20}; reg_b = 3;
        fire("add fwd", 32'h23, 1'b0, 0, 0);

        clear_in();
        rs1 = 0; fwd_rd = {5'd9, 5'd0}; fwd_we = 2'b01; fwd_data = {32'h0, 32'hFF}; reg_a = 0; reg_b = 5;
        fire("x0 no fwd", 32'h5, 1'b0, 0, 0);

        clear_in();
        alu_op = 7; reg_a = 32'h80000000; imm = 4; b_sel = 1;
        fire("sra imm", 32'hF8000000, 1'b0, 0, 0);

        clear_in();
        alu_op = 1; reg_a = 3; reg_b = 5;
        fire("sub", 32'hFFFFFFFE, 1'b0, 0, 0);

        // branches: forwarded rs1 feeds comparator, target = pc + imm
        clear_in();
        a_sel = 1; b_sel = 1; imm = 32'h20; is_jump = 1; jump_conditional = 1;
        rs1 = 3; rs2 = 4; fwd_rd = {5'd3, 5'd8}; fwd_we = 2'b11;
        fwd_data = {32'hFFFFFFFF, 32'h0}; reg_a = 7; reg_b = 1;
        funct3 = 4; fire("blt fwd", 32'h120, 1'b1, 0, 0);
        funct3 = 6; fire("bltu fwd", 32'h120, 1'b0, 0, 0);
        funct3 = 0; jump_conditional = 0; fire("jal", 32'h120, 1'b1, 0, 0);

        md_op("mul",    0, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 33, 9);
        md_op("mulh",   1, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 33, 9);
        md_op("mulhsu", 2, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 33, 9);
        md_op("mulhu",  3, 32'hFFFFFFFF, 2, 32'h00000001, 33, 9);
        md_op("div0",   4, 7, 0, 32'hFFFFFFFF, 1, 1);
        md_op("rem0",   6, 7, 0, 32'h7, 1, 1);
        md_op("divovf", 4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
        md_op("removf", 6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1);
        md_op("div neg", 4, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 33, 9);
        md_op("rem neg", 6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 33, 9);
        md_op("divu",   5, 100, 7, 32'd14, 33, 9);
        md_op("remu",   7, 100, 7, 32'd2, 33, 9);

        // flush in the same cycle as a valid ADD
        clear_in();
        reg_a = 1; reg_b = 1;
        @(posedge clk); #1 in_valid = 1; flush = 1;
        @(negedge clk);
        chk("flush wins out_valid", 32'(ov[0]), 0);
        @(posedge clk); #1 in_valid = 0; flush = 0;

        // flush at RUN cycle 10 of a MUL
        clear_in();
        is_md = 1; reg_a = 9; reg_b = 9;
        @(posedge clk); #1 in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(negedge clk);
        chk("flush run busy before", 32'(bsy[0]), 1);
        chk("flush run out_valid", 32'(ov[0]), 0);
        @(posedge clk); #1 flush = 0; is_md = 0;
        @(negedge clk);
        chk("flush run in_ready after", 32'(rdy[0]), 1);
        reg_a = 4; reg_b = 6;
        fire("add after flush", 32'hA, 1'b0, 0, 0);

        // asynchronous reset mid-RUN
        clear_in();
        is_md = 1; reg_a = 9; reg_b = 9;
        @(posedge clk); #1 in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (4) @(posedge clk);
        #1 chk("reset mid busy before", 32'(bsy[0]), 1);
        #2 reset = 0;
        #1;
        chk("reset mid busy", 32'(bsy[0]), 0);
        chk("reset mid out_valid", 32'(ov[0]), 0);
        chk("reset mid in_ready", 32'(rdy[0]), 1);
        chk("reset mid result", res[0], 0);
        @(posedge clk); #3 reset = 1;
        clear_in();
        reg_a = 32'h11; reg_b = 32'h22;
        fire("add after reset", 32'h33, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
